// File: rtl/dm_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dm_arb_pkg                                                    |
// | Description : Shared types and constants for the data-memory arbiter:      |
// |               FSM state encoding, owner encodings and datapath widths.      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package dm_arb_pkg;

    localparam int DM_ADDR_W = 8;
    localparam int DM_DATA_W = 32;

    // Owner encodings: which requester holds (or last held) the RAM.
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } dm_state_e;

endpackage : dm_arb_pkg
`default_nettype wire

// File: rtl/dm_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dm_arb_pick                                                   |
// | Description : Combinational grant selection between the CPU and the        |
// |               loader/debug port.                                            |
// |               Build option DM_ARB_RR_EN: when defined, a tie is granted to  |
// |               the port that is not the current owner (round-robin); when    |
// |               undefined, a tie always goes to the CPU (fixed priority).     |
// | Ports       : cpu_req, dbg_req  - pending requests                          |
// |               owner             - current/last grantee                      |
// |               grant_valid       - at least one request pending              |
// |               grant_owner       - selected port (OWN_CPU / OWN_DBG)         |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module dm_arb_pick
    import dm_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic dbg_req,
    input  logic owner,
    output logic grant_valid,
    output logic grant_owner
);

`ifndef DM_ARB_RR_EN
    // Fixed priority never looks at the previous owner.
    logic w_unused_owner;
    assign w_unused_owner = owner;
`endif

    always_comb begin
        grant_valid = cpu_req | dbg_req;
        grant_owner = OWN_CPU;
        if (cpu_req && dbg_req) begin
`ifdef DM_ARB_RR_EN
            grant_owner = ~owner;
`else
            grant_owner = OWN_CPU;
`endif
        end else if (dbg_req) begin
            grant_owner = OWN_DBG;
        end
    end

endmodule : dm_arb_pick
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dm_arbiter                                                    |
// | Description : Two-port arbiter in front of a single-port data RAM with a   |
// |               combinational read path. Each access takes exactly three     |
// |               cycles: IDLE (grant + latch), ACC (RAM strobe), DONE (ack).   |
// |               Build option DM_ARB_RR_EN selects round-robin tie-breaking    |
// |               (see dm_arb_pick); default is fixed CPU priority.             |
// | Ports       : clk, clr (sync, active-high)                                  |
// |               cpu_*  - MEM-stage request/ack/read data/stall                |
// |               dbg_*  - loader/debug request/ack/read data                   |
// |               ram_*  - RAM strobe, direction, address, data                 |
// |               owner  - current/last grantee (0=CPU, 1=DBG)                  |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module dm_arbiter
    import dm_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 clr,

    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [DM_ADDR_W-1:0] cpu_addr,
    input  logic [DM_DATA_W-1:0] cpu_wdata,
    output logic                 cpu_ack,
    output logic [DM_DATA_W-1:0] cpu_rdata,
    output logic                 cpu_stall,

    input  logic                 dbg_req,
    input  logic                 dbg_we,
    input  logic [DM_ADDR_W-1:0] dbg_addr,
    input  logic [DM_DATA_W-1:0] dbg_wdata,
    output logic                 dbg_ack,
    output logic [DM_DATA_W-1:0] dbg_rdata,

    output logic                 ram_cs,
    output logic                 ram_rd,
    output logic [DM_ADDR_W-1:0] ram_addr,
    output logic [DM_DATA_W-1:0] ram_wdata,
    input  logic [DM_DATA_W-1:0] ram_rdata,

    output logic                 owner
);

    dm_state_e              r_state;
    dm_state_e              w_state_nxt;

    logic                   r_owner;
    logic                   r_we;
    logic [DM_ADDR_W-1:0]   r_addr;
    logic [DM_DATA_W-1:0]   r_wdata;
    logic [DM_DATA_W-1:0]   r_cpu_rdata;
    logic [DM_DATA_W-1:0]   r_dbg_rdata;

    logic                   w_grant_valid;
    logic                   w_grant_owner;

    dm_arb_pick u_pick (
        .cpu_req     (cpu_req),
        .dbg_req     (dbg_req),
        .owner       (r_owner),
        .grant_valid (w_grant_valid),
        .grant_owner (w_grant_owner)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and Moore outputs. Requests are only sampled in IDLE, so a
    // req still high during DONE can never be serviced twice.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        ram_cs      = 1'b0;
        cpu_ack     = 1'b0;
        dbg_ack     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_state_nxt = ST_ACC;
                end
            end
            ST_ACC: begin
                ram_cs      = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                cpu_ack     = (r_owner == OWN_CPU);
                dbg_ack     = (r_owner == OWN_DBG);
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latches and per-port read-data registers. The winner's
    // command is frozen at grant time so later input changes on that port
    // cannot disturb the access in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            r_owner     <= OWN_CPU;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_grant_valid) begin
                r_owner <= w_grant_owner;
                if (w_grant_owner == OWN_DBG) begin
                    r_we    <= dbg_we;
                    r_addr  <= dbg_addr;
                    r_wdata <= dbg_wdata;
                end else begin
                    r_we    <= cpu_we;
                    r_addr  <= cpu_addr;
                    r_wdata <= cpu_wdata;
                end
            end
            // Read data is captured at the edge that closes ACC; writes
            // leave the previous read value untouched.
            if ((r_state == ST_ACC) && !r_we) begin
                if (r_owner == OWN_DBG) begin
                    r_dbg_rdata <= ram_rdata;
                end else begin
                    r_cpu_rdata <= ram_rdata;
                end
            end
        end
    end

    assign ram_rd    = ~r_we;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign cpu_rdata = r_cpu_rdata;
    assign dbg_rdata = r_dbg_rdata;
    assign owner     = r_owner;
    assign cpu_stall = cpu_req & ~cpu_ack;

endmodule : dm_arbiter
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dm_arbiter                                                 |
// | Description : Directed self-checking bench for dm_arbiter with a simple    |
// |               256x32 RAM model. Expected values follow the build option    |
// |               DM_ARB_RR_EN where tie-breaking matters.                      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        clr;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req, dbg_we;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        ram_cs, ram_rd;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        owner;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_cs && !ram_rd) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr];

    dm_arbiter dut (
        .clk       (clk),
        .clr       (clr),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata),
        .ram_cs    (ram_cs),
        .ram_rd    (ram_rd),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .owner     (owner)
    );

    // Stimulus driver only: starts and ends 1 ns after a rising edge in an
    // IDLE cycle; samples 2 ns after each edge. lat = cycles to ack,
    // stalls = sampled cycles with the port waiting, cs_mask = ram_cs history.
    task automatic port_access(input bit is_dbg, input bit we, input logic [7:0] addr,
                               input logic [31:0] wdata, output int lat, output int stalls,
                               output logic [31:0] rd, output logic [3:0] cs_mask);
        bit waiting;
        bit acked;
        if (is_dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        lat = 0; stalls = 0; rd = '0; cs_mask = '0;
        #1;
        for (int i = 0; i < 16; i++) begin
            if (i < 4) cs_mask[i] = ram_cs;
            waiting = is_dbg ? (dbg_req & ~dbg_ack) : cpu_stall;
            acked   = is_dbg ? dbg_ack : cpu_ack;
            if (waiting) stalls++;
            if (acked) begin
                rd = is_dbg ? dbg_rdata : cpu_rdata;
                break;
            end
            @(posedge clk); #2;
            lat++;
        end
        if (is_dbg) dbg_req = 1'b0; else cpu_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        repeat (3) @(posedge clk);
        #2;
        n_vec++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL reset_cpu_ack: got %0b want 0", cpu_ack); end
        n_vec++; if (dbg_ack !== 1'b0) begin n_bad++; $display("FAIL reset_dbg_ack: got %0b want 0", dbg_ack); end
        n_vec++; if (ram_cs !== 1'b0) begin n_bad++; $display("FAIL reset_ram_cs: got %0b want 0", ram_cs); end
        n_vec++; if (owner !== 1'b0) begin n_bad++; $display("FAIL reset_owner: got %0b want 0", owner); end
        n_vec++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL reset_cpu_stall: got %0b want 0", cpu_stall); end
        n_vec++; if (cpu_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_cpu_rdata: got %h want 0", cpu_rdata); end
        n_vec++; if (dbg_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_dbg_rdata: got %h want 0", dbg_rdata); end
        n_vec++; if (ram_addr !== 8'h0) begin n_bad++; $display("FAIL reset_ram_addr: got %h want 0", ram_addr); end
        n_vec++; if (ram_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_ram_wdata: got %h want 0", ram_wdata); end
        clr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_write_read();
        int lat, st;
        logic [31:0] rd;
        logic [3:0] cs;
        port_access(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, lat, st, rd, cs);
        n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL cpu_wr_latency: got %0d want 2", lat); end
        n_vec++; if (st !== 2) begin n_bad++; $display("FAIL cpu_wr_stall_cycles: got %0d want 2", st); end
        n_vec++; if (cs !== 4'b0010) begin n_bad++; $display("FAIL cpu_wr_cs_pattern: got %b want 0010", cs); end
        n_vec++; if (mem[8'h10] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL cpu_wr_ram: got %h want deadbeef", mem[8'h10]); end
        port_access(1'b0, 1'b0, 8'h10, 32'h0, lat, st, rd, cs);
        n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL cpu_rd_latency: got %0d want 2", lat); end
        n_vec++; if (st !== 2) begin n_bad++; $display("FAIL cpu_rd_stall_cycles: got %0d want 2", st); end
        n_vec++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL cpu_rd_data: got %h want deadbeef", rd); end
        n_vec++; if (owner !== 1'b0) begin n_bad++; $display("FAIL cpu_rd_owner: got %0b want 0", owner); end
    endtask

    task automatic test_simultaneous();
        int lat, st;
        logic [31:0] rd;
        logic [3:0] cs;
        int cpu_at, dbg_at, cst, both;
        logic [31:0] cpu_got;
        int exp_cpu_at, exp_dbg_at, exp_cst;
`ifdef DM_ARB_RR_EN
        exp_cpu_at = 5; exp_dbg_at = 2; exp_cst = 5;
`else
        exp_cpu_at = 2; exp_dbg_at = 5; exp_cst = 2;
`endif
        port_access(1'b0, 1'b1, 8'h01, 32'hA5A50001, lat, st, rd, cs);
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h01; cpu_wdata = '0;
        dbg_req = 1; dbg_we = 1; dbg_addr = 8'h02; dbg_wdata = 32'h5;
        cpu_at = -1; dbg_at = -1; cst = 0; both = 0; cpu_got = '0;
        #1;
        for (int c = 0; c < 16; c++) begin
            if (cpu_stall) cst++;
            if (cpu_ack && dbg_ack) both++;
            if (cpu_ack) begin cpu_at = c; cpu_got = cpu_rdata; cpu_req = 0; end
            if (dbg_ack) begin dbg_at = c; dbg_req = 0; end
            if (!cpu_req && !dbg_req) break;
            @(posedge clk); #2;
        end
        cpu_req = 0; dbg_req = 0;
        @(posedge clk); #1;
        n_vec++; if (cpu_at !== exp_cpu_at) begin n_bad++; $display("FAIL tie_cpu_ack_cycle: got %0d want %0d", cpu_at, exp_cpu_at); end
        n_vec++; if (dbg_at !== exp_dbg_at) begin n_bad++; $display("FAIL tie_dbg_ack_cycle: got %0d want %0d", dbg_at, exp_dbg_at); end
        n_vec++; if (cst !== exp_cst) begin n_bad++; $display("FAIL tie_cpu_stall_cycles: got %0d want %0d", cst, exp_cst); end
        n_vec++; if (both !== 0) begin n_bad++; $display("FAIL tie_ack_overlap: got %0d want 0", both); end
        n_vec++; if (cpu_got !== 32'hA5A50001) begin n_bad++; $display("FAIL tie_cpu_rdata: got %h want a5a50001", cpu_got); end
        n_vec++; if (mem[8'h02] !== 32'h5) begin n_bad++; $display("FAIL tie_dbg_ram: got %h want 5", mem[8'h02]); end
    endtask

    task automatic test_back_to_back();
        int  ck, dk, n, cw, dw, cmax, dmax, both;
        bit  seq [6];
        bit  exp_seq [6];
        int  exp_cmax, exp_dmax;
`ifdef DM_ARB_RR_EN
        exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_cmax = 5; exp_dmax = 5;
`else
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_cmax = 2; exp_dmax = 11;
`endif
        for (int i = 0; i < 6; i++) seq[i] = 1'b0;
        ck = 0; dk = 0; n = 0; cw = 0; dw = 0; cmax = 0; dmax = 0; both = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h80; cpu_wdata = 32'hC0000000;
        dbg_req = 1; dbg_we = 1; dbg_addr = 8'h90; dbg_wdata = 32'hD0000000;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (cpu_ack && dbg_ack) both++;
            if (cpu_req && !cpu_ack) cw++;
            if (dbg_req && !dbg_ack) dw++;
            if (cpu_ack) begin
                if (n < 6) seq[n] = 1'b0;
                n++; ck++;
                if (cw > cmax) cmax = cw;
                cw = 0;
                if (ck == 3) cpu_req = 0;
                else begin cpu_addr = 8'h80 + 8'(ck); cpu_wdata = 32'hC0000000 | 32'(ck); end
            end
            if (dbg_ack) begin
                if (n < 6) seq[n] = 1'b1;
                n++; dk++;
                if (dw > dmax) dmax = dw;
                dw = 0;
                if (dk == 3) dbg_req = 0;
                else begin dbg_addr = 8'h90 + 8'(dk); dbg_wdata = 32'hD0000000 | 32'(dk); end
            end
            if (!cpu_req && !dbg_req) break;
            @(posedge clk); #2;
        end
        cpu_req = 0; dbg_req = 0;
        @(posedge clk); #1;
        n_vec++; if (n !== 6) begin n_bad++; $display("FAIL b2b_access_count: got %0d want 6", n); end
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (seq[i] !== exp_seq[i]) begin
                n_bad++; $display("FAIL b2b_grant_%0d: got owner %0b want %0b", i, seq[i], exp_seq[i]);
            end
        end
        n_vec++; if (cmax !== exp_cmax) begin n_bad++; $display("FAIL b2b_cpu_max_wait: got %0d want %0d", cmax, exp_cmax); end
        n_vec++; if (dmax !== exp_dmax) begin n_bad++; $display("FAIL b2b_dbg_max_wait: got %0d want %0d", dmax, exp_dmax); end
        n_vec++; if (both !== 0) begin n_bad++; $display("FAIL b2b_ack_overlap: got %0d want 0", both); end
        n_vec++; if (mem[8'h82] !== 32'hC0000002) begin n_bad++; $display("FAIL b2b_cpu_ram: got %h want c0000002", mem[8'h82]); end
        n_vec++; if (mem[8'h92] !== 32'hD0000002) begin n_bad++; $display("FAIL b2b_dbg_ram: got %h want d0000002", mem[8'h92]); end
    endtask

    task automatic test_addr_change();
        int lat, st;
        logic [31:0] rd;
        logic [3:0] cs;
        logic a_cs, a_ack;
        logic [7:0] a_addr;
        logic [31:0] a_wdata;
        port_access(1'b0, 1'b1, 8'h30, 32'h77, lat, st, rd, cs);
        port_access(1'b0, 1'b1, 8'h20, 32'h0, lat, st, rd, cs);
        dbg_req = 1; dbg_we = 1; dbg_addr = 8'h20; dbg_wdata = 32'hCAFE0020;
        @(posedge clk); #1;
        dbg_addr = 8'h30; dbg_wdata = 32'hBAD00030;
        #1;
        a_cs = ram_cs; a_addr = ram_addr; a_wdata = ram_wdata;
        @(posedge clk); #2;
        a_ack = dbg_ack;
        dbg_req = 0;
        @(posedge clk); #1;
        n_vec++; if (a_cs !== 1'b1) begin n_bad++; $display("FAIL chg_acc_cs: got %0b want 1", a_cs); end
        n_vec++; if (a_addr !== 8'h20) begin n_bad++; $display("FAIL chg_acc_addr: got %h want 20", a_addr); end
        n_vec++; if (a_wdata !== 32'hCAFE0020) begin n_bad++; $display("FAIL chg_acc_wdata: got %h want cafe0020", a_wdata); end
        n_vec++; if (a_ack !== 1'b1) begin n_bad++; $display("FAIL chg_dbg_ack: got %0b want 1", a_ack); end
        n_vec++; if (mem[8'h20] !== 32'hCAFE0020) begin n_bad++; $display("FAIL chg_ram_20: got %h want cafe0020", mem[8'h20]); end
        n_vec++; if (mem[8'h30] !== 32'h77) begin n_bad++; $display("FAIL chg_ram_30: got %h want 77", mem[8'h30]); end
    endtask

    task automatic test_clr_in_acc();
        logic acc_cs;
        dbg_req = 1; dbg_we = 1; dbg_addr = 8'h40; dbg_wdata = 32'h1234;
        @(posedge clk); #1;
        clr = 1; dbg_req = 0;
        #1;
        acc_cs = ram_cs;
        @(posedge clk); #2;
        n_vec++; if (acc_cs !== 1'b1) begin n_bad++; $display("FAIL clr_acc_cs: got %0b want 1", acc_cs); end
        n_vec++; if (dbg_ack !== 1'b0) begin n_bad++; $display("FAIL clr_dbg_ack: got %0b want 0", dbg_ack); end
        n_vec++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL clr_cpu_ack: got %0b want 0", cpu_ack); end
        n_vec++; if (ram_cs !== 1'b0) begin n_bad++; $display("FAIL clr_ram_cs: got %0b want 0", ram_cs); end
        n_vec++; if (owner !== 1'b0) begin n_bad++; $display("FAIL clr_owner: got %0b want 0", owner); end
        n_vec++; if (ram_addr !== 8'h0) begin n_bad++; $display("FAIL clr_ram_addr: got %h want 0", ram_addr); end
        n_vec++; if (ram_wdata !== 32'h0) begin n_bad++; $display("FAIL clr_ram_wdata: got %h want 0", ram_wdata); end
        n_vec++; if (cpu_rdata !== 32'h0) begin n_bad++; $display("FAIL clr_cpu_rdata: got %h want 0", cpu_rdata); end
        n_vec++; if (dbg_rdata !== 32'h0) begin n_bad++; $display("FAIL clr_dbg_rdata: got %h want 0", dbg_rdata); end
        n_vec++; if (mem[8'h40] !== 32'h1234) begin n_bad++; $display("FAIL clr_ram_commit: got %h want 1234", mem[8'h40]); end
        clr = 0;
        @(posedge clk); #2;
        n_vec++; if (dbg_ack !== 1'b0) begin n_bad++; $display("FAIL clr_no_late_ack: got %0b want 0", dbg_ack); end
        @(posedge clk); #1;
    endtask

    task automatic test_read_after_dbg_write();
        int lat, st;
        logic [31:0] rd;
        logic [3:0] cs;
        port_access(1'b1, 1'b0, 8'h10, 32'h0, lat, st, rd, cs);
        n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL dbg_rd_latency: got %0d want 2", lat); end
        n_vec++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL dbg_rd_data: got %h want deadbeef", rd); end
        n_vec++; if (owner !== 1'b1) begin n_bad++; $display("FAIL dbg_rd_owner: got %0b want 1", owner); end
        port_access(1'b1, 1'b1, 8'h11, 32'h55, lat, st, rd, cs);
        n_vec++; if (dbg_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL dbg_wr_keeps_rdata: got %h want deadbeef", dbg_rdata); end
        port_access(1'b0, 1'b0, 8'h11, 32'h0, lat, st, rd, cs);
        n_vec++; if (rd !== 32'h55) begin n_bad++; $display("FAIL cpu_rd_after_dbg_wr: got %h want 55", rd); end
        n_vec++; if (cs !== 4'b0010) begin n_bad++; $display("FAIL cpu_rd_cs_pattern: got %b want 0010", cs); end
        n_vec++; if (dbg_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL cpu_rd_keeps_dbg_rdata: got %h want deadbeef", dbg_rdata); end
        n_vec++; if (owner !== 1'b0) begin n_bad++; $display("FAIL cpu_rd_owner: got %0b want 0", owner); end
    endtask

    initial begin
        test_reset();
        test_cpu_write_read();
        test_simultaneous();
        test_back_to_back();
        test_addr_change();
        test_clr_in_acc();
        test_read_after_dbg_write();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_dm_arbiter
`default_nettype wire
